// File: rtl/gemv_pkg.sv
// Shared definitions for the streaming tiled GEMV engine: FSM state encoding,
// default accumulator width and the int8 output rounding/saturation helpers.
package gemv_pkg;

   localparam int unsigned AccWidthDefault = 32;

   typedef enum logic [2:0] {
      StIdle,
      StLoadX,
      StRowW,
      StRowBias,
      StEmit,
      StDone
   } state_e;

   // Arithmetic right shift with round-half-up (toward +inf on exact halves).
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input logic [4:0]         sh);
      logic signed [63:0] half;
      if (sh == 5'd0) return v;
      half = 64'sd1 <<< (sh - 5'd1);
      return (v + half) >>> sh;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned        dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/tile_dot.sv
// One-tile dot product: TILE_SIZE masked signed multipliers feeding an adder
// tree, with a single registered output stage.
module tile_dot #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned TILE_SIZE  = 32
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            in_valid,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0] x_data,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0] w_data,
   input  logic [TILE_SIZE-1:0]            lane_mask,
   output logic                            out_valid,
   output logic [ACC_WIDTH-1:0]            out_sum
);

   localparam int unsigned Leaves = 1 << $clog2(TILE_SIZE);

   logic signed [2*DATA_WIDTH-1:0] xa;
   logic signed [2*DATA_WIDTH-1:0] wa;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic        [ACC_WIDTH-1:0]    tree [Leaves];
   logic        [ACC_WIDTH-1:0]    sum_d, sum_q;
   logic                           valid_d, valid_q;

   always_comb begin
      xa   = '0;
      wa   = '0;
      prod = '0;
      for (int i = 0; i < Leaves; i++) tree[i] = '0;
      for (int i = 0; i < TILE_SIZE; i++) begin
         xa = (2*DATA_WIDTH)'(signed'(x_data[i*DATA_WIDTH +: DATA_WIDTH]));
         wa = (2*DATA_WIDTH)'(signed'(w_data[i*DATA_WIDTH +: DATA_WIDTH]));
         if (lane_mask[i]) prod = xa * wa;
         else              prod = '0;
         tree[i] = ACC_WIDTH'(prod);
      end
      // Pairwise reduction in place; level s only reads entries below 2*s.
      for (int s = Leaves / 2; s >= 1; s = s / 2) begin
         for (int i = 0; i < s; i++) tree[i] = tree[2*i] + tree[2*i+1];
      end
      sum_d   = tree[0];
      valid_d = in_valid;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (valid_d) sum_q <= sum_d;
      end
   end

   assign out_valid = valid_q;
   assign out_sum   = sum_q;

endmodule

// File: rtl/tile_gemv_stream.sv
// Streaming matrix-vector engine: buffers x once, then streams weight rows tile
// by tile, optionally adds bias, post-processes and emits one result per row.
module tile_gemv_stream
   import gemv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = AccWidthDefault,
   parameter int unsigned TILE_SIZE  = 32,
   parameter int unsigned MAX_ROWS   = 1024,
   parameter int unsigned MAX_COLS   = 1024
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic [$clog2(MAX_ROWS+1)-1:0]       rows,
   input  logic [$clog2(MAX_COLS+1)-1:0]       cols,
   input  logic                                bias_en,
   input  logic                                relu_en,
   input  logic                                out_int8,
   input  logic [4:0]                          shift,
   input  logic                                x_valid,
   output logic                                x_ready,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0]     x_data,
   input  logic                                w_valid,
   output logic                                w_ready,
   input  logic [TILE_SIZE*DATA_WIDTH-1:0]     w_data,
   input  logic                                b_valid,
   output logic                                b_ready,
   input  logic [DATA_WIDTH-1:0]               b_data,
   output logic                                y_valid,
   input  logic                                y_ready,
   output logic [ACC_WIDTH-1:0]                y_data,
   output logic                                y_last,
   output logic                                busy,
   output logic                                done
);

   localparam int unsigned RowW  = $clog2(MAX_ROWS + 1);
   localparam int unsigned ColW  = $clog2(MAX_COLS + 1);
   localparam int unsigned Beats = (MAX_COLS + TILE_SIZE - 1) / TILE_SIZE;
   localparam int unsigned BeatW = $clog2(Beats + 1);
   localparam int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned LaneW = TILE_SIZE * DATA_WIDTH;

   state_e               state_d, state_q;
   logic [RowW-1:0]      rows_d, rows_q, row_d, row_q;
   logic [ColW-1:0]      cols_d, cols_q;
   logic [BeatW-1:0]     tiles_d, tiles_q, beat_d, beat_q;
   logic                 bias_en_d, bias_en_q, relu_en_d, relu_en_q;
   logic                 out_int8_d, out_int8_q;
   logic [4:0]           shift_d, shift_q;
   logic                 wdone_d, wdone_q;
   logic [ACC_WIDTH-1:0] acc_d, acc_q;
   logic [ACC_WIDTH-1:0] y_data_d, y_data_q;
   logic signed [63:0]   post_wide;

   logic [LaneW-1:0]     xbuf_q [Beats];
   logic                 xbuf_we;
   logic [LaneW-1:0]     x_tile;
   logic [TILE_SIZE-1:0] lane_mask;
   logic                 dot_in_valid, dot_valid;
   logic [ACC_WIDTH-1:0] dot_sum;
   logic                 last_beat, last_row;

   assign x_tile    = xbuf_q[beat_q[IdxW-1:0]];
   assign last_beat = (beat_q == tiles_q - BeatW'(1));
   assign last_row  = (row_q == rows_q - RowW'(1));

   // Lanes past the end of the row (only possible in the final beat) are zeroed.
   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < TILE_SIZE; i++) begin
         lane_mask[i] = (32'(beat_q) * TILE_SIZE + 32'(i)) < 32'(cols_q);
      end
   end

   tile_dot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .TILE_SIZE  (TILE_SIZE)
   ) u_tile_dot (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (dot_in_valid),
      .x_data    (x_tile),
      .w_data    (w_data),
      .lane_mask (lane_mask),
      .out_valid (dot_valid),
      .out_sum   (dot_sum)
   );

   always_comb begin
      state_d      = state_q;
      rows_d       = rows_q;
      cols_d       = cols_q;
      tiles_d      = tiles_q;
      beat_d       = beat_q;
      row_d        = row_q;
      bias_en_d    = bias_en_q;
      relu_en_d    = relu_en_q;
      out_int8_d   = out_int8_q;
      shift_d      = shift_q;
      wdone_d      = wdone_q;
      acc_d        = acc_q;
      y_data_d     = y_data_q;
      post_wide    = '0;
      xbuf_we      = 1'b0;
      dot_in_valid = 1'b0;
      x_ready      = 1'b0;
      w_ready      = 1'b0;
      b_ready      = 1'b0;
      y_valid      = 1'b0;
      y_last       = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               rows_d     = rows;
               cols_d     = cols;
               tiles_d    = BeatW'((32'(cols) + TILE_SIZE - 1) / TILE_SIZE);
               bias_en_d  = bias_en;
               relu_en_d  = relu_en;
               out_int8_d = out_int8;
               shift_d    = shift;
               beat_d     = '0;
               row_d      = '0;
               wdone_d    = 1'b0;
               acc_d      = '0;
               state_d    = (rows == '0 || cols == '0) ? StDone : StLoadX;
            end
         end
         StLoadX: begin
            x_ready = 1'b1;
            if (x_valid) begin
               xbuf_we = 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = StRowW;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StRowW: begin
            w_ready = !wdone_q;
            if (w_valid && !wdone_q) begin
               dot_in_valid = 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  wdone_d = 1'b1;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
            if (dot_valid) acc_d = acc_q + dot_sum;
            // The final beat's product lands the cycle after its acceptance.
            if (wdone_q && dot_valid) begin
               wdone_d = 1'b0;
               state_d = bias_en_q ? StRowBias : StEmit;
            end
         end
         StRowBias: begin
            b_ready = 1'b1;
            if (b_valid) begin
               acc_d   = acc_q + ACC_WIDTH'(signed'(b_data));
               state_d = StEmit;
            end
         end
         StEmit: begin
            y_valid = 1'b1;
            y_last  = last_row;
            if (y_ready) begin
               acc_d = '0;
               if (last_row) begin
                  state_d = StDone;
               end else begin
                  row_d   = row_q + RowW'(1);
                  state_d = StRowW;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Result is captured once on entry to EMIT so y_data stays stable under stall.
      if (state_d == StEmit && state_q != StEmit) begin
         post_wide = 64'(signed'(acc_d));
         if (relu_en_q && post_wide[63]) post_wide = '0;
         if (out_int8_q) post_wide = saturate(round_shift(post_wide, shift_q), DATA_WIDTH);
         y_data_d = ACC_WIDTH'(post_wide);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         rows_q     <= '0;
         cols_q     <= '0;
         tiles_q    <= '0;
         beat_q     <= '0;
         row_q      <= '0;
         bias_en_q  <= 1'b0;
         relu_en_q  <= 1'b0;
         out_int8_q <= 1'b0;
         shift_q    <= '0;
         wdone_q    <= 1'b0;
         acc_q      <= '0;
         y_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         tiles_q    <= tiles_d;
         beat_q     <= beat_d;
         row_q      <= row_d;
         bias_en_q  <= bias_en_d;
         relu_en_q  <= relu_en_d;
         out_int8_q <= out_int8_d;
         shift_q    <= shift_d;
         wdone_q    <= wdone_d;
         acc_q      <= acc_d;
         y_data_q   <= y_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (xbuf_we) xbuf_q[beat_q[IdxW-1:0]] <= x_data;
   end

   assign y_data = y_data_q;

endmodule

// File: tb/tb_tile_gemv_stream.sv
// Directed bench for tile_gemv_stream with a 4-lane tile and hand-computed results.
module tb_tile_gemv_stream;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  rows = '0;
   logic [4:0]  cols = '0;
   logic        bias_en = 1'b0;
   logic        relu_en = 1'b0;
   logic        out_int8 = 1'b0;
   logic [4:0]  shift = '0;
   logic        x_valid = 1'b0;
   logic        x_ready;
   logic [31:0] x_data = '0;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [31:0] w_data = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [7:0]  b_data = '0;
   logic        y_valid;
   logic        y_ready = 1'b0;
   logic [31:0] y_data;
   logic        y_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tile_gemv_stream #(
      .DATA_WIDTH (8),
      .ACC_WIDTH  (32),
      .TILE_SIZE  (4),
      .MAX_ROWS   (16),
      .MAX_COLS   (16)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .rows     (rows),
      .cols     (cols),
      .bias_en  (bias_en),
      .relu_en  (relu_en),
      .out_int8 (out_int8),
      .shift    (shift),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .x_data   (x_data),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_data   (w_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y_data   (y_data),
      .y_last   (y_last),
      .busy     (busy),
      .done     (done)
   );

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      logic [7:0] la, lb, lc, ld;
      la = 8'(a);
      lb = 8'(b);
      lc = 8'(c);
      ld = 8'(d);
      return {ld, lc, lb, la};
   endfunction

   task automatic do_start(input int r, input int c, input logic be, input logic re,
                           input logic oi, input int sh);
      rows     = 5'(r);
      cols     = 5'(c);
      bias_en  = be;
      relu_en  = re;
      out_int8 = oi;
      shift    = 5'(sh);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic push_x(input logic [31:0] d);
      int n;
      n = 0;
      x_data  = d;
      x_valid = 1'b1;
      while (x_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (x_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL push_x timeout: x_ready=%b, want 1", x_ready);
      end
      @(negedge clk);
      x_valid = 1'b0;
   endtask

   task automatic push_w(input logic [31:0] d);
      int n;
      n = 0;
      w_data  = d;
      w_valid = 1'b1;
      while (w_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (w_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL push_w timeout: w_ready=%b, want 1", w_ready);
      end
      @(negedge clk);
      w_valid = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] d);
      int n;
      n = 0;
      b_data  = d;
      b_valid = 1'b1;
      while (b_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (b_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL push_b timeout: b_ready=%b, want 1", b_ready);
      end
      @(negedge clk);
      b_valid = 1'b0;
   endtask

   task automatic wait_y(output bit ok);
      int n;
      n = 0;
      while (y_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      ok = (y_valid === 1'b1);
   endtask

   task automatic pop_y();
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, x_ready, w_ready, b_ready, y_valid, y_last} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, want 0000000",
                  {busy, done, x_ready, w_ready, b_ready, y_valid, y_last});
      end
      checks++;
      if (y_data !== 32'd0) begin
         errors++; $display("FAIL reset_y_data: got %h, want 0", y_data);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || x_ready !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy=%b x_ready=%b, want 0 0", busy, x_ready);
      end
   endtask

   task automatic test_raw();
      bit ok;
      do_start(2, 3, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (busy !== 1'b1 || x_ready !== 1'b1 || w_ready !== 1'b0) begin
         errors++;
         $display("FAIL raw_load_x: busy=%b x_ready=%b w_ready=%b, want 1 1 0",
                  busy, x_ready, w_ready);
      end
      push_x(pk(1, 2, 3, 7));
      push_w(pk(1, 1, 1, 5));
      wait_y(ok);
      checks++;
      if (!ok || y_data !== 32'd6 || y_last !== 1'b0) begin
         errors++;
         $display("FAIL raw_row0: y_data=%0d last=%b valid=%b, want 6 0 1", y_data, y_last, ok);
      end
      checks++;
      if (w_ready !== 1'b0 || x_ready !== 1'b0) begin
         errors++; $display("FAIL raw_emit_ready: w_ready=%b x_ready=%b, want 0 0", w_ready, x_ready);
      end
      pop_y();
      push_w(pk(-1, 0, 2, -9));
      wait_y(ok);
      checks++;
      if (!ok || y_data !== 32'd5 || y_last !== 1'b1) begin
         errors++;
         $display("FAIL raw_row1: y_data=%0d last=%b valid=%b, want 5 1 1", y_data, y_last, ok);
      end
      pop_y();
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || y_valid !== 1'b0) begin
         errors++;
         $display("FAIL raw_done: done=%b busy=%b y_valid=%b, want 1 1 0", done, busy, y_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL raw_idle: done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_multi_tile();
      bit ok;
      do_start(1, 6, 1'b0, 1'b0, 1'b0, 0);
      push_x(pk(1, 1, 1, 1));
      push_x(pk(1, 1, 9, 9));
      push_w(pk(2, 2, 2, 2));
      push_w(pk(2, 2, 100, -100));
      checks++;
      if (w_ready !== 1'b0) begin
         errors++; $display("FAIL mt_w_ready_after_last: got %b, want 0", w_ready);
      end
      wait_y(ok);
      checks++;
      if (!ok || y_data !== 32'd12 || y_last !== 1'b1) begin
         errors++;
         $display("FAIL mt_result: y_data=%0d last=%b valid=%b, want 12 1 1", y_data, y_last, ok);
      end
      pop_y();
      @(negedge clk);
   endtask

   task automatic test_int8();
      bit ok;
      logic [31:0] wv [3];
      logic [31:0] ev [3];
      wv = '{pk(5, 5, 0, 0), pk(5, 5, 4, 0), pk(-5, -5, -4, -1)};
      ev = '{32'd125, 32'd126, 32'hFFFF_FF82};
      do_start(3, 4, 1'b0, 1'b0, 1'b1, 3);
      push_x(pk(100, 100, 1, 1));
      for (int r = 0; r < 3; r++) begin
         push_w(wv[r]);
         wait_y(ok);
         checks++;
         if (!ok || y_data !== ev[r] || y_last !== (r == 2)) begin
            errors++;
            $display("FAIL int8_shift3_row%0d: y_data=%h last=%b, want %h %b",
                     r, y_data, y_last, ev[r], (r == 2));
         end
         pop_y();
      end
      @(negedge clk);
      wv = '{pk(5, 5, 10, 10), pk(0, 0, -50, 0), 32'd0};
      ev = '{32'd127, 32'd0, 32'd0};
      do_start(2, 4, 1'b0, 1'b1, 1'b1, 2);
      push_x(pk(100, 100, 1, 1));
      for (int r = 0; r < 2; r++) begin
         push_w(wv[r]);
         wait_y(ok);
         checks++;
         if (!ok || y_data !== ev[r] || y_last !== (r == 1)) begin
            errors++;
            $display("FAIL int8_sat_relu_row%0d: y_data=%h last=%b, want %h %b",
                     r, y_data, y_last, ev[r], (r == 1));
         end
         pop_y();
      end
      @(negedge clk);
   endtask

   task automatic test_bias_backpressure();
      bit ok;
      do_start(1, 1, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (b_ready !== 1'b0) begin
         errors++; $display("FAIL bias_b_ready_early: got %b, want 0", b_ready);
      end
      push_x(pk(5, 33, -7, 1));
      push_w(pk(2, 50, 50, 50));
      push_b(8'hFC);
      wait_y(ok);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (!ok || y_valid !== 1'b1 || y_data !== 32'd6 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL bias_stall_cycle%0d: valid=%b y_data=%0d w_ready=%b, want 1 6 0",
                     c, y_valid, y_data, w_ready);
         end
         @(negedge clk);
      end
      pop_y();
      @(negedge clk);
   endtask

   task automatic test_rows_zero();
      do_start(0, 4, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (done !== 1'b1 || {x_ready, w_ready, b_ready} !== 3'b000) begin
         errors++;
         $display("FAIL rows0_done: done=%b readys=%b, want 1 000", done, {x_ready, w_ready, b_ready});
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rows0_idle: done=%b busy=%b, want 0 0", done, busy);
      end
      do_start(3, 0, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (done !== 1'b1 || x_ready !== 1'b0) begin
         errors++; $display("FAIL cols0_done: done=%b x_ready=%b, want 1 0", done, x_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit bad;
      do_start(2, 8, 1'b0, 1'b0, 1'b0, 0);
      push_x(pk(1, 1, 1, 1));
      push_x(pk(1, 1, 1, 1));
      push_w(pk(1, 1, 1, 1));
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || w_ready !== 1'b0 || y_valid !== 1'b0 || y_data !== 32'd0) begin
         errors++;
         $display("FAIL midreset_async: busy=%b w_ready=%b y_valid=%b y_data=%h, want 0 0 0 0",
                  busy, w_ready, y_valid, y_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      x_valid = 1'b1;
      w_valid = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (y_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      x_valid = 1'b0;
      w_valid = 1'b0;
      checks++;
      if (bad) begin
         errors++; $display("FAIL midreset_quiet: activity seen=%b, want 0", bad);
      end
      do_start(1, 1, 1'b0, 1'b0, 1'b0, 0);
      push_x(pk(3, 0, 0, 0));
      push_w(pk(4, 0, 0, 0));
      wait_y(ok);
      checks++;
      if (!ok || y_data !== 32'd12 || y_last !== 1'b1) begin
         errors++;
         $display("FAIL midreset_recover: y_data=%0d last=%b valid=%b, want 12 1 1",
                  y_data, y_last, ok);
      end
      pop_y();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_raw();
      test_multi_tile();
      test_int8();
      test_bias_backpressure();
      test_rows_zero();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tile_gemv_stream.md
TILE_GEMV_STREAM -- requirements
Module: tile_gemv_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed element width of x, w and bias.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed accumulator and raw-output width.
REQ-003 SHALL have parameter TILE_SIZE, default 32: elements per x or w beat.
REQ-004 SHALL have parameter MAX_ROWS, default 1024, and MAX_COLS, default 1024: runtime dimension limits.
REQ-005 SHALL have ports clk (in, 1, clock) and reset_n (in, 1, asynchronous active-low reset); one clock, reset asynchronous and active-low.
REQ-006 SHALL have start (in, 1), the start pulse; and rows (in, clog2(MAX_ROWS+1)) and cols (in, clog2(MAX_COLS+1)), sampled on start.
REQ-007 SHALL have mode inputs, all sampled on start: bias_en (in, 1), relu_en (in, 1), out_int8 (in, 1), shift (in, 5).
REQ-008 SHALL have the x stream: x_valid (in, 1), x_ready (out, 1), x_data (in, TILE_SIZE*DATA_WIDTH); lane i is bits [i*DW +: DW].
REQ-009 SHALL have the weight stream: w_valid (in, 1), w_ready (out, 1), w_data (in, TILE_SIZE*DATA_WIDTH).
REQ-010 SHALL have the bias stream: b_valid (in, 1), b_ready (out, 1), b_data (in, DATA_WIDTH).
REQ-011 SHALL have the output stream: y_valid (out, 1), y_ready (in, 1), y_data (out, ACC_WIDTH), y_last (out, 1).
REQ-012 SHALL have status outputs busy (out, 1) and done (out, 1, one-cycle pulse).

Function
REQ-013 SHALL define T = ceil(cols/TILE_SIZE); every stream transfers on valid&&ready in the same cycle.
REQ-014 SHALL implement FSM states IDLE, LOAD_X, ROW_W, ROW_BIAS, EMIT and DONE.
REQ-015 SHALL move IDLE->LOAD_X on start; when rows==0 or cols==0 it SHALL move IDLE->DONE and consume nothing; start outside IDLE is ignored.
REQ-016 LOAD_X SHALL assert x_ready, store T beats into an internal x buffer of MAX_COLS entries, then enter ROW_W.
REQ-017 ROW_W SHALL assert w_ready, accept T beats per row (each row starts on a new beat), and zero-mask lanes with column index >= cols in the last beat.
REQ-018 A tile's dot product SHALL be added to the row accumulator one cycle after acceptance; back-to-back beats SHALL be accepted at one per cycle.
REQ-019 After the final beat and its pipeline stage, the FSM SHALL go to ROW_BIAS if bias_en, otherwise to EMIT.
REQ-020 ROW_BIAS SHALL assert b_ready, add the sign-extended b_data on transfer, then go to EMIT.
REQ-021 The post-process SHALL apply ReLU (negative -> 0) if relu_en; if out_int8, it SHALL apply an arithmetic right shift by shift with round-half-up, then saturate to [-2^(DW-1), 2^(DW-1)-1], sign-extended onto y_data.
REQ-022 EMIT SHALL hold y_valid with a stable y_data until y_ready; y_last=1 on the row with index rows-1.
REQ-023 On transfer, EMIT SHALL clear the accumulator and go to ROW_W for the next row, or to DONE after the last row.
REQ-024 The accumulator SHALL wrap at ACC_WIDTH (no saturation) before post-processing.
REQ-025 DONE SHALL pulse done for exactly one cycle and then return to IDLE; busy=1 in every state except IDLE.
REQ-026 ready outputs SHALL be 0 in any state that does not consume the corresponding stream.

Reset
REQ-027 reset_n low SHALL immediately force state to IDLE and set x_ready, w_ready, b_ready, y_valid, y_last, busy and done to 0, and y_data and the accumulator to 0.
REQ-028 Reset asserted mid-operation SHALL abandon the job; after release, no output SHALL appear before a new start.

Structure
REQ-029 Package gemv_pkg SHALL hold the FSM state enum, the default ACC_WIDTH, and the saturate/round helper functions.
REQ-030 Sub-module tile_dot SHALL contain TILE_SIZE signed multipliers, lane mask inputs and an adder tree with one registered output stage.
REQ-031 The x buffer SHALL be a single-write-port array indexed by beat.

Verification
REQ-032 Raw mode: rows=2, cols=3, x={1,2,3}, w rows {1,1,1},{-1,0,2}, bias off -> y_data 6 then 5, y_last on the second output, done one cycle later.
REQ-033 Multi-tile with padding: TILE_SIZE=4, cols=6, x all 1, w all 2 with garbage in padded lanes -> y_data=12.
REQ-034 int8 mode: accumulator 1000, shift=3 -> 125; accumulator 1020, shift=2 -> 127 (saturated); with relu_en, accumulator -50 -> 0.
REQ-035 Bias plus backpressure: bias_en, b_data=-4, accumulator 10, y_ready held low 5 cycles -> y_data=6 held stable and w_ready=0 throughout.
REQ-036 rows=0 -> done one cycle after start with no ready asserted; reset_n pulsed mid ROW_W -> busy=0, no y_valid until the next start.
